// File: rtl/mcoi_display_driver.sv
// mcoi_display_driver
// Front-panel display refresh engine. An 8-row frame buffer is written by the
// status logic. Each row is serialised MSB-first into an external shift chain,
// selected on csel, latched, and then lit for a fixed dwell time, row after row.
module mcoi_display_driver #(
  parameter int WIDTH   = 32,   // bits per row (external chain length), >= 2
  parameter int CLK_DIV = 4,    // clk cycles per sclk half period, >= 1
  parameter int DWELL   = 1000  // clk cycles a row is lit, >= 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             wr_en_i,
  input  logic [2:0]       wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             frame_done_o,
  output logic             latch,
  output logic             blank,
  output logic [2:0]       csel,
  output logic             sclk,
  output logic             sin
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);
  // Count value one cycle before the final dwell cycle; only consulted when DWELL >= 2.
  localparam logic [DW_W-1:0]  DW_PRE   = DW_W'((DWELL >= 2) ? DWELL - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_BLANK,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] buf_q [8];
  logic [2:0]       row_q;
  logic [2:0]       row_d;
  logic [WIDTH-1:0] shreg_q;
  logic [DIV_W-1:0] div_q;
  logic [BIT_W-1:0] bit_q;
  logic [DW_W-1:0]  dw_q;
  logic             blank_q;
  logic             latch_q;
  logic             sclk_q;
  logic             sin_q;
  logic [2:0]       csel_q;
  logic             frame_done_q;

  // Row that follows the current one; the 3-bit add wraps 7 back to 0.
  assign row_d = row_q + 3'd1;

  // Frame buffer: written by the status logic in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the buffer must read back as zero straight after reset, so this
      // small register file is cleared explicitly rather than left uninitialised.
      for (int i = 0; i < 8; i++) buf_q[i] <= '0;
    end else if (wr_en_i) begin
      buf_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Refresh sequencer: shift, blank setup, latch pulse, dwell; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every state update here is non-blocking so that the buffer read
      // below sees the pre-write value when a write lands on the snapshot edge.
      state_q      <= S_IDLE;
      row_q        <= '0;
      shreg_q      <= '0;
      div_q        <= '0;
      bit_q        <= '0;
      dw_q         <= '0;
      blank_q      <= 1'b1;
      latch_q      <= 1'b0;
      sclk_q       <= 1'b0;
      sin_q        <= 1'b0;
      csel_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          blank_q <= 1'b1;
          sclk_q  <= 1'b0;
          latch_q <= 1'b0;
          if (enable_i) begin
            shreg_q <= buf_q[row_q];
            sin_q   <= buf_q[row_q][WIDTH-1];
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (div_q != DIV_LAST) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // End of the high phase: sclk falls and the next bit is presented.
              sclk_q  <= 1'b0;
              shreg_q <= shreg_q << 1;
              if (bit_q == BIT_LAST) begin
                sin_q   <= 1'b0;
                csel_q  <= row_q;
                state_q <= S_BLANK;
              end else begin
                sin_q <= shreg_q[WIDTH-2];
                bit_q <= bit_q + 1'b1;
              end
            end
          end
        end

        S_BLANK: begin
          if (div_q != DIV_LAST) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q   <= '0;
            latch_q <= 1'b1;
            state_q <= S_LATCH;
          end
        end

        S_LATCH: begin
          if (div_q != DIV_LAST) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q        <= '0;
            latch_q      <= 1'b0;
            blank_q      <= 1'b0;
            dw_q         <= '0;
            // With a one-cycle dwell the first display cycle is also the last.
            frame_done_q <= (DWELL == 1) && (row_q == 3'd7);
            state_q      <= S_DISPLAY;
          end
        end

        S_DISPLAY: begin
          if (dw_q != DW_LAST) begin
            dw_q         <= dw_q + 1'b1;
            // Raise the pulse so it coincides with the final dwell cycle of row 7.
            frame_done_q <= (dw_q == DW_PRE) && (row_q == 3'd7);
          end else begin
            row_q   <= row_d;
            blank_q <= 1'b1;
            if (enable_i) begin
              shreg_q <= buf_q[row_d];
              sin_q   <= buf_q[row_d][WIDTH-1];
              div_q   <= '0;
              bit_q   <= '0;
              state_q <= S_SHIFT;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign frame_done_o = frame_done_q;
  assign latch        = latch_q;
  assign blank        = blank_q;
  assign csel         = csel_q;
  assign sclk         = sclk_q;
  assign sin          = sin_q;

endmodule

// File: tb/tb_mcoi_display_driver.sv
// Testbench for mcoi_display_driver (WIDTH=8, CLK_DIV=2, DWELL=10).
// The reference model describes each row visit as an offset into a 46-cycle
// row period; a modelled 8-bit shift chain with output latch captures what the
// board would actually display.
module tb_mcoi_display_driver;

  localparam int W      = 8;
  localparam int CD     = 2;
  localparam int DW     = 10;
  localparam int SH_LEN = W * 2 * CD;
  localparam int PERIOD = SH_LEN + 2 * CD + DW;
  localparam int FRAME  = 8 * PERIOD;

  logic         clk;
  logic         rst;
  logic         enable_i;
  logic         wr_en_i;
  logic [2:0]   wr_addr_i;
  logic [W-1:0] wr_data_i;
  logic         frame_done_o;
  logic         latch;
  logic         blank;
  logic [2:0]   csel;
  logic         sclk;
  logic         sin;

  mcoi_display_driver #(
    .WIDTH  (W),
    .CLK_DIV(CD),
    .DWELL  (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable_i),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .frame_done_o(frame_done_o),
    .latch       (latch),
    .blank       (blank),
    .csel        (csel),
    .sclk        (sclk),
    .sin         (sin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Reference model state
  logic [W-1:0] mbuf [8];
  bit           act;
  int           mrow;
  int           t;
  logic [W-1:0] pat;
  logic [2:0]   csel_m;

  // Board-side observation state
  logic [W-1:0] chain;
  logic         prev_sclk, prev_latch, prev_blank;
  logic [2:0]   prev_csel;
  logic [CD-1:0] sin_hist;
  int           rise_cnt, lat_hi, fd_gap, blow, fd_count, lat_total;
  bit           clean, have_prev;
  logic [W-1:0] last_lat [8];
  int           lat_count [8];
  logic [2:0]   last_lat_csel;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: capture inputs, advance the model, compare, run board monitors.
  task automatic step();
    logic r, e, w;
    logic [2:0] a;
    logic [W-1:0] d;
    logic eb, el, es, ef;
    r = rst; e = enable_i; w = wr_en_i; a = wr_addr_i; d = wr_data_i;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 8; i++) begin
        mbuf[i] = '0;
        lat_count[i] = 0;
      end
      act = 0; mrow = 0; t = 0; csel_m = '0;
    end else begin
      if (act) begin
        t++;
        if (t == PERIOD) begin
          mrow = (mrow + 1) % 8;
          if (e) begin
            pat = mbuf[mrow];
            t = 0;
          end else begin
            act = 0;
          end
        end
      end else if (e) begin
        act = 1; t = 0; pat = mbuf[mrow];
      end
      if (act && t == SH_LEN) csel_m = 3'(mrow);
      if (w) mbuf[a] = d;
    end

    eb = !(act && t >= SH_LEN + 2 * CD);
    el = act && (t >= SH_LEN + CD) && (t < SH_LEN + 2 * CD);
    es = act && (t < SH_LEN) && (((t / CD) % 2) == 1);
    ef = act && (t == PERIOD - 1) && (mrow == 7);
    check("blank", blank, eb);
    check("latch", latch, el);
    check("sclk", sclk, es);
    check("frame_done", frame_done_o, ef);
    check("csel", csel, csel_m);
    if (act && t < SH_LEN) check("sin_bit", sin, pat[W - 1 - t / (2 * CD)]);
    if (r) check("sin_reset", sin, 0);

    if (r) begin
      rise_cnt = 0; lat_hi = 0; clean = 0; have_prev = 0; fd_count = 0;
    end else begin
      if (sclk && !prev_sclk) begin
        check("sin_hold", sin, sin_hist[CD-1]);
        chain = {chain[W-2:0], sin};
        rise_cnt++;
      end
      if (latch && !prev_latch) begin
        check("rises_per_row", rise_cnt, W);
        check("chain_latched", chain, pat);
        rise_cnt = 0;
        last_lat[csel] = chain;
        lat_count[csel]++;
        lat_total++;
        last_lat_csel = csel;
      end
      if (latch) lat_hi++;
      if (!blank && prev_blank) begin
        check("latch_cycles", lat_hi, CD);
        lat_hi = 0;
      end
      if (!blank) check("csel_stable", csel, prev_csel);
      check("latch_vs_sclk", latch & sclk, 0);
      fd_gap++;
      if (!blank) blow++;
      if (!e) clean = 0;
      if (frame_done_o) begin
        fd_count++;
        if (clean && have_prev) begin
          check("frame_gap", fd_gap, FRAME);
          check("blank_low_per_frame", blow, 8 * DW);
        end
        have_prev = 1; clean = 1; fd_gap = 0; blow = 0;
      end
    end
    prev_sclk = sclk; prev_latch = latch; prev_blank = blank; prev_csel = csel;
    sin_hist = {sin_hist[CD-2:0], sin};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int lt;
    total = 0; bad = 0;
    rst = 1'b1; enable_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    act = 0; mrow = 0; t = 0; pat = '0; csel_m = '0; chain = '0;
    prev_sclk = 0; prev_latch = 0; prev_blank = 1; prev_csel = '0; sin_hist = '0;
    rise_cnt = 0; lat_hi = 0; fd_gap = 0; blow = 0; fd_count = 0; lat_total = 0;
    clean = 0; have_prev = 0; last_lat_csel = '0;
    for (int i = 0; i < 8; i++) begin
      mbuf[i] = '0; last_lat[i] = '0; lat_count[i] = 0;
    end

    // Reset state
    step(); step();
    check("rst_blank", blank, 1);
    check("rst_latch", latch, 0);
    check("rst_sclk", sclk, 0);
    check("rst_csel", csel, 0);
    check("rst_fd", frame_done_o, 0);
    rst = 1'b0;

    // Empty buffer, continuous refresh for two frames
    enable_i = 1'b1;
    repeat (2 * FRAME + 20) step();
    check("t1_frame_pulses", fd_count, 2);
    for (int i = 0; i < 8; i++) check("t1_row_visits", lat_count[i], 2);
    for (int i = 0; i < 8; i++) check("t1_row_blank", last_lat[i], 0);

    // Rows 3 and 7 patterned
    enable_i = 1'b0;
    for (int i = 0; i < 100 && act; i++) step();
    check("t2_idle", act, 0);
    rst = 1'b1; step(); rst = 1'b0;
    wr_en_i = 1'b1; wr_addr_i = 3'd3; wr_data_i = 8'hA5; step();
    wr_addr_i = 3'd7; wr_data_i = 8'h81; step();
    wr_en_i = 1'b0;
    enable_i = 1'b1;
    repeat (FRAME + 5) step();
    check("t2_row3_count", lat_count[3], 1);
    check("t2_row3", last_lat[3], 8'hA5);
    check("t2_row7", last_lat[7], 8'h81);
    check("t2_row0", last_lat[0], 8'h00);

    // Write row 0 on the very edge that snapshots it
    enable_i = 1'b0;
    for (int i = 0; i < 100 && act; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    enable_i = 1'b1; wr_en_i = 1'b1; wr_addr_i = 3'd0; wr_data_i = 8'hFF; step();
    wr_en_i = 1'b0;
    for (int i = 0; i < 100 && lat_count[0] < 1; i++) step();
    check("t3_first_seen", lat_count[0], 1);
    check("t3_first_pass", last_lat[0], 8'h00);
    for (int i = 0; i < FRAME + 50 && lat_count[0] < 2; i++) step();
    check("t3_second_seen", lat_count[0], 2);
    check("t3_second_pass", last_lat[0], 8'hFF);

    // Drop enable midway through row 2's shift
    for (int i = 0; i < 200 && !(act && mrow == 2 && t == 16); i++) step();
    check("t4_reach_row2", act && mrow == 2 && t == 16, 1);
    enable_i = 1'b0;
    for (int i = 0; i < 200 && act; i++) step();
    check("t4_idle", act, 0);
    check("t4_last_row", last_lat_csel, 2);
    repeat (10) step();
    check("t4_idle_blank", blank, 1);
    check("t4_idle_sclk", sclk, 0);
    lt = lat_total;
    enable_i = 1'b1;
    for (int i = 0; i < 100 && lat_total == lt; i++) step();
    check("t4_resume_row", last_lat_csel, 3);

    // Reset during row 5's dwell
    for (int i = 0; i < 300 && !(act && mrow == 5 && t == 40); i++) step();
    check("t5_reach_row5", act && mrow == 5 && t == 40, 1);
    rst = 1'b1; step();
    check("t5_blank", blank, 1);
    check("t5_csel", csel, 0);
    check("t5_latch", latch, 0);
    check("t5_sclk", sclk, 0);
    check("t5_sin", sin, 0);
    rst = 1'b0;

    // Buffer reads back cleared on the next frame
    repeat (FRAME + 5) step();
    for (int i = 0; i < 8; i++) begin
      check("t6_visit", lat_count[i], 1);
      check("t6_cleared", last_lat[i], 0);
    end

    // Randomised writes, enable drops and occasional resets
    for (int n = 0; n < 1500; n++) begin
      enable_i  = ($urandom_range(0, 15) != 0);
      wr_en_i   = ($urandom_range(0, 3) == 0);
      wr_addr_i = 3'($urandom);
      wr_data_i = W'($urandom);
      rst       = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0; wr_en_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcoi_display_driver.md
Name: mcoi_display_driver

Overview:
- Multiplexed front-panel display driver inside mcoi_xu5_top; it drives the latch, blank, csel, sclk and sin board pins.
- Holds an 8-row frame buffer written by the status logic.
- Continuously refreshes the display: each row's bits are serialised MSB-first into the external shift-register chain, the row is selected on csel, the data is latched, and the row is lit for a fixed dwell time.

Parameters:
- WIDTH, 32, bits per row (length of the external shift chain); must be ≥ 2.
- CLK_DIV, 4, clk cycles per sclk half-period; also the blank-setup and latch pulse length; must be ≥ 1.
- DWELL, 1000, clk cycles a row is lit (blank low); must be ≥ 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable_i  input  1  refresh enable.
- wr_en_i  input  1  frame-buffer write strobe.
- wr_addr_i  input  3  row index to write.
- wr_data_i  input  WIDTH  row pattern; bit WIDTH-1 is shifted first.
- frame_done_o  output  1  one-cycle pulse at the end of row 7's dwell.
- latch  output  1  shift-chain storage latch, active high.
- blank  output  1  display blank, high = dark.
- csel  output  3  row select.
- sclk  output  1  shift clock; data is sampled by the chain on the rising edge.
- sin  output  1  serial data.

Behaviour:
- Reset: frame buffer cleared to 0, row pointer 0, state IDLE. Outputs: blank=1, latch=0, sclk=0, sin=0, csel=0, frame_done_o=0.
- Frame buffer is 8 x WIDTH registers.
  - Write takes effect the cycle after a wr_en_i=1 edge; writes are accepted in every state.
- States: IDLE, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE:
  - blank=1, sclk=0, latch=0.
  - If enable_i=1, load buffer[row] into the shift register and go to SHIFT.
  - Snapshot rule: if the same cycle writes to that row, the old value is loaded.
- SHIFT:
  - Lasts WIDTH*2*CLK_DIV cycles; blank=1.
  - Per bit: sin = shift-register MSB, driven for the whole bit. sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles.
  - Shift register moves left when sclk returns low, so sin is stable ≥ CLK_DIV cycles around each rising sclk edge.
  - After the last high phase: sclk=0, go to BLANK.
- BLANK:
  - csel=row on entry; blank=1 for CLK_DIV cycles.
  - csel only ever changes while blank=1.
  - Then go to LATCH.
- LATCH: latch=1 for CLK_DIV cycles, then latch=0, go to DISPLAY.
- DISPLAY:
  - blank=0 for DWELL cycles.
  - At the last cycle: row = row+1 mod 8 (7 wraps to 0). frame_done_o=1 for exactly one cycle when the finishing row is 7.
  - Then, if enable_i=1: load the next row and go to SHIFT; else go to IDLE with blank=1.
- Row period = WIDTH*2*CLK_DIV + 2*CLK_DIV + DWELL cycles.
- enable_i=0 mid-row: the current row completes through DISPLAY, then the block goes to IDLE. The row pointer is retained, and refresh resumes at the next row.
- rst=1 in any state: next cycle matches reset values exactly, including the frame buffer. No glitch requirement on outputs beyond that.
- Writes during SHIFT/BLANK/LATCH/DISPLAY do not affect the pattern already being shifted; they show up at the row's next visit.
- frame_done_o is never asserted in IDLE.

Test Plan (WIDTH=8, CLK_DIV=2, DWELL=10; row period 46, frame 368 cycles; the bench models an 8-bit shift chain plus output latch):
- Reset, then enable_i=1 with an empty buffer:
  - Required: 8 rising sclk edges per row, sin=0 throughout, csel cycling 0..7.
  - Required: frame_done_o single-cycle pulses every 368 cycles; blank low exactly 10 of every 46 cycles.
- Write row3=0xA5, row7=0x81, then enable:
  - Required: the modelled chain latches 0xA5 when csel=3 and 0x81 when csel=7; sin bit order MSB first.
  - Required: on every rising sclk, sin equals the value held at the preceding falling edge.
- Write row0=0xFF in the same cycle as the IDLE→SHIFT snapshot of row 0 (old value 0x00):
  - Required: 0x00 is displayed on the first pass and 0xFF on the second.
- Deassert enable_i midway through row 2's SHIFT:
  - Required: row 2 completes latch and dwell, then blank=1 and sclk idles.
  - Required: on re-enable, csel goes to 3 first.
- Assert rst for 1 cycle during DISPLAY of row 5:
  - Required: next cycle blank=1, csel=0, latch=0, sclk=0, sin=0; buffer reads 0.
- Protocol checks over a full frame:
  - Required: csel never changes while blank=0; latch never high while sclk=1.
  - Required: latch high exactly 2 cycles per row.
